// File: rtl/mac_sequencer.sv
// Sequential multiply-accumulate engine: accepts len operand pairs, multiplies each
// with a WIDTH-cycle shift-add and accumulates into a sticky-overflow accumulator.
module mac_sequencer #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 16,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             op_valid,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             op_ready,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] result,
  output logic             overflow
);

  localparam int BIT_W = $clog2(WIDTH) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_MULT  = 3'd2;
  localparam logic [2:0] S_ACC   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [BIT_W-1:0]   bit_q, bit_d;

  logic [ACC_W:0]     acc_sum;
  logic [LEN_W-1:0]   cnt_inc;

  // Extra top bit of acc_sum is the carry-out that feeds the sticky overflow.
  assign acc_sum = {1'b0, acc_q} + (ACC_W+1)'(prod_q);
  assign cnt_inc = cnt_q + LEN_W'(1);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    bit_d    = bit_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (len != '0) begin
            len_d   = len;
            cnt_d   = '0;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: begin
        if (op_valid) begin
          mcand_d  = (2*WIDTH)'(op_a);
          mplier_d = op_b;
          prod_d   = '0;
          bit_d    = '0;
          state_d  = S_MULT;
        end
      end
      S_MULT: begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        bit_d    = bit_q + BIT_W'(1);
        if (bit_q == BIT_W'(WIDTH-1)) state_d = S_ACC;
      end
      S_ACC: begin
        acc_d = acc_sum[ACC_W-1:0];
        if (acc_sum[ACC_W]) ovf_d = 1'b1;
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == len_q) ? S_DONE : S_FETCH;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      bit_q    <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      bit_q    <= bit_d;
    end
  end

  assign op_ready = (state_q == S_FETCH);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign result   = acc_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: latency, results, overflow, stalls, ignored start
// and asynchronous reset, each compared against hand-computed values.
module tb_mac_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  len;
  logic        op_valid;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        op_ready;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        overflow;

  int checks   = 0;
  int failures = 0;
  int rdy;

  mac_sequencer #(.WIDTH(8), .ACC_W(16), .LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b),
    .op_ready(op_ready), .busy(busy), .done(done),
    .result(result), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_op_ready"}, 32'(op_ready), 32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_done"},     32'(done),     32'd0);
    chk({tag, "_result"},   32'(result),   32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  // Called away from a clock edge. Pair i is a[i]/b[i]; pair gap_idx is preceded by
  // gap_len cycles of op_valid=0; start is pulsed again when lat == poke_at.
  task automatic run_op(input string tag, input int n,
                        input logic [3:0][7:0] a, input logic [3:0][7:0] b,
                        input int gap_idx, input int gap_len, input int poke_at,
                        input int exp_lat, input logic [15:0] exp_res,
                        input logic exp_ovf, output int rdy_cnt);
    int lat, idx, stall;
    lat = 0; idx = 0; stall = 0; rdy_cnt = 0;
    start = 1'b1; len = 4'(n); op_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; len = 4'hF;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    while (done !== 1'b1 && lat < 100) begin
      start = (lat == poke_at);
      len   = 4'($urandom_range(1, 15));
      if (op_ready === 1'b1) begin
        rdy_cnt++;
        if (idx == gap_idx && stall < gap_len) begin
          op_valid = 1'b0;
          stall++;
        end else begin
          op_valid = 1'b1;
          op_a = a[idx];
          op_b = b[idx];
          idx++;
        end
      end else begin
        op_valid = (idx != gap_idx || stall >= gap_len);
        op_a = 8'($urandom);
        op_b = 8'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0; op_valid = 1'b0;
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_result"}, 32'(result), 32'(exp_res));
    chk({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_result_hold"}, 32'(result), 32'(exp_res));
    chk({tag, "_ovf_hold"}, 32'(overflow), 32'(exp_ovf));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; op_valid = 1'b0; op_a = '0; op_b = '0;
    #12;
    chk_idle_outputs("por");
    #10 rst_n = 1'b1;

    // First rising edge after reset release accepts start.
    run_op("single", 1, {8'd0, 8'd0, 8'd0, 8'd3}, {8'd0, 8'd0, 8'd0, 8'd5},
           -1, 0, -1, 10, 16'd15, 1'b0, rdy);

    run_op("multi", 3, {8'd0, 8'd255, 8'd3, 8'd1}, {8'd0, 8'd1, 8'd4, 8'd2},
           -1, 0, -1, 30, 16'd269, 1'b0, rdy);
    chk("multi_ready_cycles", 32'(rdy), 32'd3);

    run_op("ovf", 2, {8'd0, 8'd0, 8'd255, 8'd255}, {8'd0, 8'd0, 8'd255, 8'd255},
           -1, 0, -1, 20, 16'd64514, 1'b1, rdy);

    // Asynchronous reset mid-cycle from a state with nonzero result and overflow.
    #3 rst_n = 1'b0;
    #1;
    chk_idle_outputs("async_rst");
    #3 rst_n = 1'b1;

    run_op("after_ovf", 1, {8'd0, 8'd0, 8'd0, 8'd2}, {8'd0, 8'd0, 8'd0, 8'd2},
           -1, 0, -1, 10, 16'd4, 1'b0, rdy);

    run_op("len0", 0, '0, '0, -1, 0, -1, 0, 16'd0, 1'b0, rdy);

    run_op("gap", 2, {8'd0, 8'd0, 8'd20, 8'd10}, {8'd0, 8'd0, 8'd20, 8'd10},
           1, 2, -1, 22, 16'd500, 1'b0, rdy);
    chk("gap_ready_cycles", 32'(rdy), 32'd4);

    run_op("busy_start", 2, {8'd0, 8'd0, 8'd7, 8'd5}, {8'd0, 8'd0, 8'd8, 8'd6},
           -1, 0, 5, 20, 16'd86, 1'b0, rdy);

    // Reset while the multiplier is running.
    start = 1'b1; len = 4'd1;
    @(posedge clk); #1;
    start = 1'b0; op_valid = 1'b1; op_a = 8'd100; op_b = 8'd100;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle_outputs("mid_rst");
    #2 rst_n = 1'b1;
    run_op("post_rst", 1, {8'd0, 8'd0, 8'd0, 8'd7}, {8'd0, 8'd0, 8'd0, 8'd9},
           -1, 0, -1, 10, 16'd63, 1'b0, rdy);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: unsigned operand width.
REQ-002 The block SHALL have parameter ACC_W, default 16: accumulator and result width.
REQ-003 The block SHALL have parameter LEN_W, default 4: width of the pair-count input.
REQ-004 Port clk  input  1: single clock, all state updates on the rising edge.
REQ-005 Port rst_n  input  1: asynchronous, active-low reset.
REQ-006 Port start  input  1: begin an operation; sampled only in IDLE.
REQ-007 Port len  input  LEN_W: number of operand pairs; captured when start is accepted.
REQ-008 Port op_valid  input  1: an operand pair is present on op_a/op_b.
REQ-009 Port op_a  input  WIDTH: multiplicand.
REQ-010 Port op_b  input  WIDTH: multiplier.
REQ-011 Port op_ready  output  1: the block can accept a pair; high only in FETCH.
REQ-012 Port busy  output  1: high in every state except IDLE.
REQ-013 Port done  output  1: one-cycle completion pulse, high only in DONE.
REQ-014 Port result  output  ACC_W: accumulated sum of products.
REQ-015 Port overflow  output  1: sticky flag, set on any accumulator carry-out in the current operation.

Function
REQ-016 The block SHALL implement states IDLE, FETCH, MULT, ACC and DONE.
REQ-017 In IDLE with start=1 and len!=0, the block SHALL capture len, clear the accumulator, pair count and overflow, and enter FETCH on the next cycle.
REQ-018 In IDLE with start=1 and len=0, the block SHALL clear result and overflow and enter DONE on the next cycle.
REQ-019 In FETCH, when op_valid=1 (op_ready=1), the block SHALL capture op_a and op_b, clear the product register and bit counter, and enter MULT.
REQ-020 In FETCH with op_valid=0, the block SHALL hold state indefinitely with no change to the accumulator.
REQ-021 MULT SHALL last exactly WIDTH cycles of shift-add: each cycle, when the multiplier LSB is 1, the shifted multiplicand (2*WIDTH bits) is added to the product; the multiplicand then shifts left 1 and the multiplier shifts right 1.
REQ-022 After MULT, the 2*WIDTH-bit product SHALL equal op_a*op_b exactly (unsigned).
REQ-023 ACC SHALL last one cycle: acc <= (acc + zero-extended product) mod 2^ACC_W; overflow <= 1 on carry-out; pair count increments.
REQ-024 From ACC, the block SHALL enter DONE when the incremented count equals the captured len, otherwise FETCH.
REQ-025 DONE SHALL last one cycle with done=1, then the block SHALL return to IDLE.
REQ-026 result SHALL track the accumulator continuously and hold its final value in IDLE until the next accepted start.
REQ-027 overflow SHALL hold until the next accepted start.
REQ-028 start SHALL be ignored in every state except IDLE; len and the operand inputs SHALL be ignored outside their capture points.
REQ-029 Timing: if start is sampled at edge k and op_valid is held at 1, done SHALL be high in cycle k+1+N*(WIDTH+2), where N=len.
REQ-030 Each FETCH stall cycle SHALL add exactly one cycle to the REQ-029 latency.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE and clear the product, operand, counter and accumulator registers, regardless of the current state.
REQ-032 While rst_n=0, outputs SHALL be op_ready=0, busy=0, done=0, result=0, overflow=0.
REQ-033 After rst_n deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-034 Reset: assert rst_n=0 mid-simulation -> all outputs 0 asynchronously, without waiting for a clk edge.
REQ-035 Single pair: len=1, (3,5), op_valid held -> done in cycle k+11, result=15, overflow=0.
REQ-036 Multi-pair: len=3, pairs (1,2), (3,4), (255,1) -> done in cycle k+31, result=269, op_ready high in exactly 3 cycles.
REQ-037 Overflow: len=2, pairs (255,255) twice -> result=64514, overflow=1; a following len=1, (2,2) operation -> result=4, overflow=0.
REQ-038 Corner cases, each checked:
- len=0 -> done one cycle after start, result=0.
- 2-cycle op_valid gap on pair 2 of a len=2 operation -> done delayed by 2 cycles.
- start pulsed while busy -> no effect.
REQ-039 Mid-operation reset: rst_n=0 during MULT -> IDLE, busy=0; a new len=1, (7,9) operation -> result=63.
